reg_dump_ctrl: RTL and testbench

Debug read-out controller for the processor register file. On a START pulse it walks register indices FIRST_REG..LAST_REG through one register-file read port. It captures each 32-bit value and presents it to a downstream consumer (UART/seven-segment/host bridge) over a valid/ready handshake. It sits beside the datapath and shares a read address port with decode via an external mux, selected by BUSY.

---
 rtl/reg_dump_ctrl_pkg.sv | 21 ++
 rtl/reg_dump_ctrl.sv | 114 +++++++++++
 tb/tb_reg_dump_ctrl.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_dump_ctrl_pkg.sv
// Shared types and widths for the register-file dump controller.
// Holds the FSM state encoding, the index/data widths and the captured-word payload.
package reg_dump_ctrl_pkg;

    localparam int unsigned IDX_W  = 4;
    localparam int unsigned DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FETCH   = 2'd1,
        ST_PRESENT = 2'd2,
        ST_FINISH  = 2'd3
    } state_e;

    // One captured register: index plus value.
    typedef struct packed {
        logic [IDX_W-1:0]  idx;
        logic [DATA_W-1:0] data;
    } word_t;

endpackage : reg_dump_ctrl_pkg

// File: rtl/reg_dump_ctrl.sv
// Debug read-out controller: on i_start walks register indices FIRST_REG..LAST_REG
// through one register-file read port and hands each captured value downstream
// over a valid/ready handshake.
// Ports:
//   i_clk, i_reset_n   clock, synchronous active-low reset
//   i_start            dump request, sampled only while idle
//   o_rd_addr          register-file read address (0 when idle)
//   i_rd_data          combinational read data for o_rd_addr
//   o_out_data/o_out_idx/o_out_valid/i_out_ready   word handshake to the consumer
//   o_busy             dump in progress (selects this block on the external read mux)
//   o_done             one-cycle pulse after the last word is accepted
module reg_dump_ctrl
    import reg_dump_ctrl_pkg::*;
#(
    parameter int unsigned FIRST_REG = 0,
    parameter int unsigned LAST_REG  = 15
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_start,
    output logic [IDX_W-1:0]  o_rd_addr,
    input  logic [DATA_W-1:0] i_rd_data,
    output logic [DATA_W-1:0] o_out_data,
    output logic [IDX_W-1:0]  o_out_idx,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic              o_busy,
    output logic              o_done
);

    localparam logic [IDX_W-1:0] FIRST_IDX = IDX_W'(FIRST_REG);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(LAST_REG);

    // Reject an empty or out-of-range dump window when the design is elaborated.
    if ((FIRST_REG > LAST_REG) || (LAST_REG > 15)) begin : g_bad_range
        $error("reg_dump_ctrl: illegal range FIRST_REG=%0d LAST_REG=%0d", FIRST_REG, LAST_REG);
    end

    state_e           r_state;
    state_e           w_state_nxt;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] w_idx_nxt;
    logic [IDX_W-1:0] r_rd_addr;
    word_t            r_word;
    word_t            w_word_nxt;
    logic             r_valid;
    logic             r_busy;
    logic             r_done;

    // Next-state, index and capture logic.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_word_nxt  = r_word;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_state_nxt = ST_FETCH;
                    w_idx_nxt   = FIRST_IDX;
                end
            end
            ST_FETCH: begin
                // Snapshot taken on the edge leaving FETCH; a same-edge write is not seen.
                w_word_nxt  = '{idx: r_idx, data: i_rd_data};
                w_state_nxt = ST_PRESENT;
            end
            ST_PRESENT: begin
                if (r_valid && i_out_ready) begin
                    if (r_idx == LAST_IDX) begin
                        w_state_nxt = ST_FINISH;
                    end else begin
                        w_idx_nxt   = r_idx + IDX_W'(1);
                        w_state_nxt = ST_FETCH;
                    end
                end
            end
            ST_FINISH: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs, all decoded from the next state.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state   <= ST_IDLE;
            r_idx     <= '0;
            r_rd_addr <= '0;
            r_word    <= '0;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_idx     <= w_idx_nxt;
            r_word    <= w_word_nxt;
            r_rd_addr <= (w_state_nxt == ST_IDLE) ? '0 : w_idx_nxt;
            r_valid   <= (w_state_nxt == ST_PRESENT);
            r_busy    <= (w_state_nxt != ST_IDLE);
            r_done    <= (w_state_nxt == ST_FINISH);
        end
    end

    assign o_rd_addr   = r_rd_addr;
    assign o_out_data  = r_word.data;
    assign o_out_idx   = r_word.idx;
    assign o_out_valid = r_valid;
    assign o_busy      = r_busy;
    assign o_done      = r_done;

endmodule : reg_dump_ctrl

// File: tb/tb_reg_dump_ctrl.sv
// Self-checking bench for reg_dump_ctrl: three instances (full range, 3..5, 15..15)
// share one behavioural register file.
module tb_reg_dump_ctrl;

    logic        clk;
    logic        rst_n;
    logic [2:0]  start;
    logic [2:0]  ready;
    logic [2:0]  valid;
    logic [2:0]  busy;
    logic [2:0]  done;
    logic [3:0]  rd_addr [3];
    logic [31:0] rd_data [3];
    logic [31:0] out_data [3];
    logic [3:0]  out_idx [3];

    logic [31:0] rf [16];
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [31:0] wr_data;

    logic [31:0] got_data [16];
    int first_r [3] = '{0, 3, 15};
    int last_r  [3] = '{15, 5, 15};

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic        i_start;
        logic        i_ready;
        logic        e_valid;
        logic        e_busy;
        logic        e_done;
        logic [3:0]  e_rd_addr;
        logic [3:0]  e_idx;
        logic [31:0] e_data;
    } vec_t;

    vec_t tbl [34];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) if (wr_en) rf[wr_addr] <= wr_data;

    assign rd_data[0] = rf[rd_addr[0]];
    assign rd_data[1] = rf[rd_addr[1]];
    assign rd_data[2] = rf[rd_addr[2]];

    reg_dump_ctrl #(.FIRST_REG(0), .LAST_REG(15)) u_full (
        .i_clk(clk), .i_reset_n(rst_n), .i_start(start[0]), .o_rd_addr(rd_addr[0]),
        .i_rd_data(rd_data[0]), .o_out_data(out_data[0]), .o_out_idx(out_idx[0]),
        .o_out_valid(valid[0]), .i_out_ready(ready[0]), .o_busy(busy[0]), .o_done(done[0]));

    reg_dump_ctrl #(.FIRST_REG(3), .LAST_REG(5)) u_mid (
        .i_clk(clk), .i_reset_n(rst_n), .i_start(start[1]), .o_rd_addr(rd_addr[1]),
        .i_rd_data(rd_data[1]), .o_out_data(out_data[1]), .o_out_idx(out_idx[1]),
        .o_out_valid(valid[1]), .i_out_ready(ready[1]), .o_busy(busy[1]), .o_done(done[1]));

    reg_dump_ctrl #(.FIRST_REG(15), .LAST_REG(15)) u_one (
        .i_clk(clk), .i_reset_n(rst_n), .i_start(start[2]), .o_rd_addr(rd_addr[2]),
        .i_rd_data(rd_data[2]), .o_out_data(out_data[2]), .o_out_idx(out_idx[2]),
        .o_out_valid(valid[2]), .i_out_ready(ready[2]), .o_busy(busy[2]), .o_done(done[2]));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic write_reg(input int i, input logic [31:0] v);
        wr_en   = 1'b1;
        wr_addr = 4'(i);
        wr_data = v;
        @(posedge clk); #1;
        wr_en   = 1'b0;
    endtask

    // Runs one dump on instance d from idle, scoreboarding every accepted word
    // against a snapshot of the register file taken at start.
    task automatic run_dump(input int d, input int stall_idx, input int stall_n,
                            input bit rnd_ready, input bit noisy_start,
                            input int wr_idx, input logic [31:0] wr_val,
                            output int words, output int cycles);
        logic [31:0] snap [16];
        int exp_idx, stalled, last_acc, dones;
        bit prev_acc, prev_valid, acc, wr_done;
        logic [31:0] prev_data;
        logic [3:0]  prev_idx;
        for (int i = 0; i < 16; i++) snap[i] = rf[i];
        exp_idx = first_r[d];
        stalled = 0; last_acc = -10; dones = 0; words = 0; cycles = 0;
        prev_acc = 0; prev_valid = 0; wr_done = 0;
        prev_data = '0; prev_idx = '0;
        start[d] = 1'b1;
        @(posedge clk); #1;
        start[d] = 1'b0;
        chk("busy_rise", 32'(busy[d]), 32'd1);
        while (busy[d] && cycles < 300) begin
            if (prev_acc) chk("valid_drop", 32'(valid[d]), 32'd0);
            if (prev_valid && !prev_acc && valid[d]) begin
                chk("hold_idx", 32'(out_idx[d]), 32'(prev_idx));
                chk("hold_data", out_data[d], prev_data);
            end
            if (valid[d] && (out_idx[d] == 4'(stall_idx)) && stalled < stall_n) begin
                ready[d] = 1'b0;
                stalled++;
            end else if (rnd_ready) begin
                ready[d] = 1'($urandom_range(0, 1));
            end else begin
                ready[d] = 1'b1;
            end
            if (noisy_start) start[d] = done[d] ? 1'b1 : ($urandom_range(0, 3) == 0);
            if (wr_idx >= 0 && !wr_done && !valid[d] && !done[d] && rd_addr[d] == 4'(wr_idx)) begin
                wr_en = 1'b1; wr_addr = 4'(wr_idx); wr_data = wr_val; wr_done = 1;
            end else begin
                wr_en = 1'b0;
            end
            acc = valid[d] && ready[d];
            if (acc) begin
                chk("word_idx", 32'(out_idx[d]), 32'(exp_idx));
                chk("word_data", out_data[d], snap[exp_idx[3:0]]);
                got_data[out_idx[d]] = out_data[d];
                words++;
                exp_idx++;
                last_acc = cycles;
            end
            if (done[d]) begin
                dones++;
                chk("done_timing", 32'(cycles), 32'(last_acc + 1));
                chk("done_all_words", 32'(exp_idx), 32'(last_r[d] + 1));
            end
            prev_acc = acc; prev_valid = valid[d];
            prev_data = out_data[d]; prev_idx = out_idx[d];
            @(posedge clk); #1;
            cycles++;
        end
        start[d] = 1'b0; ready[d] = 1'b0; wr_en = 1'b0;
        chk("dump_ends", 32'(busy[d]), 32'd0);
        chk("word_count", 32'(words), 32'(last_r[d] - first_r[d] + 1));
        chk("done_count", 32'(dones), 32'd1);
        if (noisy_start) begin
            @(posedge clk); #1;
            chk("finish_start_ignored", 32'(busy[d]), 32'd0);
        end
    endtask

    initial begin
        int words, cycles;
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int words, cycles;
        rst_n = 1'b0; start = '0; ready = '0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;

        // Expected per-cycle outputs of a full dump with ready tied high.
        for (int c = 0; c < 34; c++) begin
            tbl[c].i_start = (c == 0);
            tbl[c].i_ready = 1'b1;
            tbl[c].e_valid = (c < 32) && (c % 2 == 1);
            tbl[c].e_busy  = (c < 33);
            tbl[c].e_done  = (c == 32);
            tbl[c].e_rd_addr = (c < 32) ? 4'(c / 2) : ((c == 32) ? 4'd15 : 4'd0);
            tbl[c].e_idx   = 4'(c / 2);
            tbl[c].e_data  = (c / 2 == 15) ? 32'h0000_0008 : 32'h1000_0000 + 32'(c / 2);
        end

        for (int i = 0; i < 16; i++)
            write_reg(i, (i == 15) ? 32'h0000_0008 : 32'h1000_0000 + 32'(i));
        @(posedge clk); #1;
        for (int d = 0; d < 3; d++) begin
            chk("rst_valid", 32'(valid[d]), 32'd0);
            chk("rst_busy", 32'(busy[d]), 32'd0);
            chk("rst_done", 32'(done[d]), 32'd0);
            chk("rst_rd_addr", 32'(rd_addr[d]), 32'd0);
            chk("rst_idx", 32'(out_idx[d]), 32'd0);
            chk("rst_data", out_data[d], 32'd0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Full dump, table driven.
        for (int r = 0; r < 34; r++) begin
            start[0] = tbl[r].i_start;
            ready[0] = tbl[r].i_ready;
            @(posedge clk); #1;
            start[0] = 1'b0;
            chk("tbl_valid", 32'(valid[0]), 32'(tbl[r].e_valid));
            chk("tbl_busy", 32'(busy[0]), 32'(tbl[r].e_busy));
            chk("tbl_done", 32'(done[0]), 32'(tbl[r].e_done));
            chk("tbl_rd_addr", 32'(rd_addr[0]), 32'(tbl[r].e_rd_addr));
            if (tbl[r].e_valid) begin
                chk("tbl_idx", 32'(out_idx[0]), 32'(tbl[r].e_idx));
                chk("tbl_data", out_data[0], tbl[r].e_data);
            end
        end
        ready[0] = 1'b0;

        // Backpressure on word 4 for 4 cycles.
        run_dump(1, 4, 4, 1'b0, 1'b0, -1, 32'h0, words, cycles);
        chk("bp_words", 32'(words), 32'd3);
        chk("bp_cycles", 32'(cycles), 32'd11);
        chk("bp_word4", got_data[4], 32'h1000_0004);

        // Snapshot race on R2, then an immediate second dump.
        run_dump(0, -1, 0, 1'b0, 1'b0, 2, 32'hDEAD_BEEF, words, cycles);
        chk("snap_old", got_data[2], 32'h1000_0002);
        chk("full_cycles", 32'(cycles), 32'd33);
        run_dump(0, -1, 0, 1'b0, 1'b0, -1, 32'h0, words, cycles);
        chk("snap_new", got_data[2], 32'hDEAD_BEEF);

        // START pulses while busy and in the FINISH cycle.
        run_dump(1, -1, 0, 1'b0, 1'b1, -1, 32'h0, words, cycles);

        // Reset while presenting word 7.
        start[0] = 1'b1;
        @(posedge clk); #1;
        start[0] = 1'b0;
        ready[0] = 1'b1;
        for (int k = 0; k < 40 && !(valid[0] && out_idx[0] == 4'd7); k++) begin
            @(posedge clk); #1;
        end
        chk("rst7_valid", 32'(valid[0]), 32'd1);
        chk("rst7_idx", 32'(out_idx[0]), 32'd7);
        ready[0] = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("rst7_o_valid", 32'(valid[0]), 32'd0);
        chk("rst7_o_busy", 32'(busy[0]), 32'd0);
        chk("rst7_o_done", 32'(done[0]), 32'd0);
        chk("rst7_o_rd_addr", 32'(rd_addr[0]), 32'd0);
        chk("rst7_o_idx", 32'(out_idx[0]), 32'd0);
        chk("rst7_o_data", out_data[0], 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst7_no_done", 32'(done[0]), 32'd0);
        chk("rst7_idle", 32'(busy[0]), 32'd0);
        run_dump(0, -1, 0, 1'b0, 1'b0, -1, 32'h0, words, cycles);

        // Single-word window at index 15.
        run_dump(2, -1, 0, 1'b0, 1'b0, -1, 32'h0, words, cycles);
        chk("one_word", got_data[15], 32'h0000_0008);
        chk("one_cycles", 32'(cycles), 32'd3);

        // Randomized dumps: random ready, random register contents, random START noise.
        for (int n = 0; n < 12; n++) begin
            int d;
            for (int w = 0; w < 3; w++) write_reg(int'($urandom_range(0, 15)), $urandom);
            d = int'($urandom_range(0, 2));
            run_dump(d, -1, 0, 1'b1, n[0], -1, 32'h0, words, cycles);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_reg_dump_ctrl
